// File: rtl/branch_resolve_predict.sv
// Branch unit for the MIPS pipeline.
// Resolves branch direction in a registered stage, predicts direction at fetch
// from a direct-mapped table of 2-bit saturating counters, and keeps
// branch / misprediction statistics.
module branch_resolve_predict #(
    parameter int         DATA_W   = 32,
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [2:0]        res_op,
    input  logic [DATA_W-1:0] res_rs,
    input  logic [DATA_W-1:0] res_rt,
    input  logic              res_pred,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_mispredict,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [1:0]       counters [DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             is_branch;
    logic             taken;
    logic             mispredict;
    logic             rs_neg;
    logic             rs_zero;
    logic             unused_pc_bits;

    // Word-aligned PCs: the two low bits never select an entry; no tags kept.
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                              res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

    // Prediction reads the table before any same-cycle update (no bypass).
    assign pred_taken = counters[pred_idx][1];

    // Op 7 is a no-branch: it still produces an output pulse but touches nothing else.
    assign is_branch  = res_valid && (res_op != 3'd7);
    assign rs_neg     = res_rs[DATA_W-1];
    assign rs_zero    = (res_rs == '0);
    assign mispredict = taken ^ res_pred;

    // Evaluate the actual branch direction from the signed operand tests.
    always_comb begin
        taken = 1'b0;
        case (res_op)
            3'd0:    taken = (res_rs == res_rt);
            3'd1:    taken = (res_rs != res_rt);
            3'd2:    taken = rs_neg || rs_zero;
            3'd3:    taken = !rs_neg && !rs_zero;
            3'd4:    taken = rs_neg;
            3'd5:    taken = !rs_neg;
            3'd6:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Train the indexed 2-bit counter toward the resolved direction, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                counters[i] <= CNT_INIT;
            end
        end else if (is_branch) begin
            if (taken) begin
                if (counters[res_idx] != 2'b11) begin
                    counters[res_idx] <= counters[res_idx] + 2'd1;
                end
            end else begin
                if (counters[res_idx] != 2'b00) begin
                    counters[res_idx] <= counters[res_idx] - 2'd1;
                end
            end
        end
    end

    // Register the resolve result one cycle after the request; outputs idle at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
        end else begin
            out_valid      <= res_valid;
            out_taken      <= is_branch && taken;
            out_mispredict <= is_branch && mispredict;
        end
    end

    // Count real branches and their mispredictions; clear wins, counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (clr_stats) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (is_branch) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + STAT_ONE;
            end
            if (mispredict && (stat_mispredicts != STAT_MAX)) begin
                stat_mispredicts <= stat_mispredicts + STAT_ONE;
            end
        end
    end

endmodule
